// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NRD combinational read ports, ALU (A) and load (B) write ports,
// same-cycle write bypass, externally supplied top register, and a pending-load scoreboard.
module regfile_mp_sb #(
    parameter int unsigned SIZE = 32,
    parameter int unsigned AW   = 4,
    parameter int unsigned NRD  = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NRD*AW-1:0]   RA,
    output logic [NRD*SIZE-1:0] RD,
    output logic [NRD-1:0]      BUSY,
    input  logic [SIZE-1:0]     R15,
    input  logic                WE_A,
    input  logic [AW-1:0]       WA_A,
    input  logic [SIZE-1:0]     WD_A,
    input  logic                WE_B,
    input  logic [AW-1:0]       WA_B,
    input  logic [SIZE-1:0]     WD_B,
    input  logic                LOCK,
    input  logic [AW-1:0]       LOCK_A,
    output logic [AW:0]         PEND
);

    localparam int unsigned NREG = 2 ** AW;
    localparam logic [AW-1:0] TopAddr = AW'(NREG - 1);

    logic [SIZE-1:0] rf_q [NREG-1];
    logic [SIZE-1:0] rf_d [NREG-1];
    logic [NREG-2:0] busy_q, busy_d;
    logic [AW:0]     pend_q, pend_d;
    logic [AW-1:0]   ra   [NRD];

    // Port B is applied after port A so a same-address collision stores the load data.
    always_comb begin
        for (int r = 0; r < int'(NREG) - 1; r++) begin
            rf_d[r] = rf_q[r];
            if (WE_A && WA_A == AW'(r)) begin
                rf_d[r] = WD_A;
            end
            if (WE_B && WA_B == AW'(r)) begin
                rf_d[r] = WD_B;
            end
        end
    end

    // A new LOCK beats a same-cycle load writeback to the same register.
    always_comb begin
        busy_d = busy_q;
        pend_d = '0;
        for (int r = 0; r < int'(NREG) - 1; r++) begin
            if (LOCK && LOCK_A == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (WE_B && WA_B == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
            pend_d = pend_d + (AW + 1)'(busy_d[r]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int r = 0; r < int'(NREG) - 1; r++) begin
                rf_q[r] <= '0;
            end
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            for (int r = 0; r < int'(NREG) - 1; r++) begin
                rf_q[r] <= rf_d[r];
            end
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        RD   = '0;
        BUSY = '0;
        for (int i = 0; i < int'(NRD); i++) begin
            ra[i] = RA[i*AW +: AW];
            if (ra[i] == TopAddr) begin
                RD[i*SIZE +: SIZE] = R15;
                BUSY[i]            = 1'b0;
            end else begin
                if (WE_B && WA_B == ra[i]) begin
                    RD[i*SIZE +: SIZE] = WD_B;
                end else if (WE_A && WA_A == ra[i]) begin
                    RD[i*SIZE +: SIZE] = WD_A;
                end else begin
                    RD[i*SIZE +: SIZE] = rf_q[ra[i]];
                end
                BUSY[i] = busy_q[ra[i]] && !(WE_B && WA_B == ra[i]);
            end
        end
    end

    assign PEND = pend_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed bypass/scoreboard/reset cases, then randomized traffic
// compared each cycle against an array-based reference model.
module tb_regfile_mp_sb;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [11:0] RA;
    logic [95:0] RD;
    logic [2:0]  BUSY;
    logic [31:0] R15;
    logic        WE_A, WE_B, LOCK;
    logic [3:0]  WA_A, WA_B, LOCK_A;
    logic [31:0] WD_A, WD_B;
    logic [4:0]  PEND;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_rf   [15];
    bit          m_busy [15];

    regfile_mp_sb #(.SIZE(32), .AW(4), .NRD(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .RA(RA), .RD(RD), .BUSY(BUSY), .R15(R15),
        .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
        .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
        .LOCK(LOCK), .LOCK_A(LOCK_A), .PEND(PEND)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input int i);
        return RD[i*32 +: 32];
    endfunction

    task automatic set_ra(input int i, input logic [3:0] a);
        RA[i*4 +: 4] = a;
    endtask

    task automatic idle();
        WE_A = 0; WE_B = 0; LOCK = 0;
        WA_A = 0; WA_B = 0; LOCK_A = 0;
        WD_A = 0; WD_B = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd15) return R15;
        if (WE_B && WA_B == a) return WD_B;
        if (WE_A && WA_A == a) return WD_A;
        return m_rf[a];
    endfunction

    function automatic logic m_busy_out(input logic [3:0] a);
        if (a == 4'd15) return 1'b0;
        return m_busy[a] && !(WE_B && WA_B == a);
    endfunction

    function automatic logic [31:0] m_pend();
        int n = 0;
        foreach (m_busy[r]) n += int'(m_busy[r]);
        return n;
    endfunction

    // Apply the cycle's inputs to the model, then advance the clock.
    task automatic tick();
        if (!RST_N) begin
            foreach (m_rf[r]) begin
                m_rf[r]   = '0;
                m_busy[r] = 0;
            end
        end else begin
            if (WE_A && WA_A != 4'd15) m_rf[WA_A] = WD_A;
            if (WE_B && WA_B != 4'd15) begin
                m_rf[WA_B]   = WD_B;
                m_busy[WA_B] = 0;
            end
            if (LOCK && LOCK_A != 4'd15) m_busy[LOCK_A] = 1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle();
        RA = '0; R15 = 32'h108; RST_N = 0;
        foreach (m_rf[r]) begin
            m_rf[r] = '0; m_busy[r] = 0;
        end
        tick();
        RST_N = 1;

        // Reset clears storage but R15 still passes through
        WE_A = 1; WA_A = 3; WD_A = 32'hDEAD;
        tick();
        idle();
        set_ra(0, 3); set_ra(1, 15);
        #1 check_eq("wr3", rd_of(0), 32'hDEAD);
        RST_N = 0;
        tick();
        RST_N = 1;
        #1;
        check_eq("rst_rd", rd_of(0), 32'h0);
        check_eq("rst_busy", 32'(BUSY), 32'h0);
        check_eq("rst_pend", 32'(PEND), 32'h0);
        check_eq("rst_r15", rd_of(1), 32'h108);

        // Same-cycle A/B collision: B wins, bypassed and stored
        WE_A = 1; WA_A = 5; WD_A = 32'h11;
        WE_B = 1; WA_B = 5; WD_B = 32'h22;
        set_ra(0, 5);
        #1 check_eq("byp_b", rd_of(0), 32'h22);
        tick();
        idle();
        #1 check_eq("store_b", rd_of(0), 32'h22);

        // Scoreboard set and same-cycle clear by load writeback
        LOCK = 1; LOCK_A = 7;
        tick();
        idle();
        set_ra(0, 7);
        #1;
        check_eq("sb_busy", 32'(BUSY[0]), 32'h1);
        check_eq("sb_pend", 32'(PEND), 32'h1);
        WE_B = 1; WA_B = 7; WD_B = 32'h55;
        #1;
        check_eq("sb_clr_busy", 32'(BUSY[0]), 32'h0);
        check_eq("sb_clr_rd", rd_of(0), 32'h55);
        tick();
        idle();
        #1 check_eq("sb_pend0", 32'(PEND), 32'h0);

        // Set beats clear; port A never clears
        LOCK = 1; LOCK_A = 2;
        tick();
        LOCK = 1; LOCK_A = 2; WE_B = 1; WA_B = 2; WD_B = 32'h77;
        tick();
        idle();
        set_ra(0, 2);
        #1;
        check_eq("svc_busy", 32'(BUSY[0]), 32'h1);
        check_eq("svc_pend", 32'(PEND), 32'h1);
        WE_A = 1; WA_A = 2; WD_A = 32'h99;
        tick();
        idle();
        #1;
        check_eq("wa_busy", 32'(BUSY[0]), 32'h1);
        check_eq("wa_pend", 32'(PEND), 32'h1);

        // Top address is never written or locked
        R15 = 32'h1234;
        WE_A = 1; WA_A = 15; WD_A = 32'hFF; LOCK = 1; LOCK_A = 15;
        set_ra(0, 15);
        #1;
        check_eq("r15_rd", rd_of(0), 32'h1234);
        check_eq("r15_busy", 32'(BUSY[0]), 32'h0);
        tick();
        idle();
        #1;
        check_eq("r15_rd2", rd_of(0), 32'h1234);
        check_eq("r15_pend", 32'(PEND), 32'h1);

        // Randomized traffic against the model
        RST_N = 0;
        tick();
        for (int c = 0; c < 10000; c++) begin
            RST_N  = ($urandom_range(0, 499) != 0);
            RA     = 12'($urandom);
            R15    = $urandom;
            WE_A   = 1'($urandom);
            WA_A   = 4'($urandom);
            WD_A   = $urandom;
            WE_B   = 1'($urandom);
            WA_B   = ($urandom_range(0, 3) == 0) ? WA_A : 4'($urandom);
            WD_B   = $urandom;
            LOCK   = ($urandom_range(0, 2) == 0);
            LOCK_A = ($urandom_range(0, 3) == 0) ? WA_B : 4'($urandom);
            #1;
            for (int i = 0; i < 3; i++) begin
                check_eq("rnd_rd", rd_of(i), m_read(RA[i*4 +: 4]));
                check_eq("rnd_busy", 32'(BUSY[i]), 32'(m_busy_out(RA[i*4 +: 4])));
            end
            check_eq("rnd_pend", 32'(PEND), m_pend());
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
